// File: rtl/spi_link_pkg.sv
// Shared definitions for the inter-board tracking link: frame layouts and FSM states.
package spi_link_pkg;

    localparam int FRAME_BITS = 32;

    // Motor-command (TX) frame layout
    localparam int TX_MX_W    = 8;
    localparam int TX_MX_LSB  = 24;
    localparam int TX_MY_W    = 7;
    localparam int TX_MY_LSB  = 17;
    localparam int TX_ETC_W   = 17;
    localparam int TX_ETC_LSB = 0;

    // Target-report (RX) frame layout
    localparam int RX_EX_W      = 10;
    localparam int RX_EX_LSB    = 22;
    localparam int RX_EY_W      = 9;
    localparam int RX_EY_LSB    = 13;
    localparam int RX_RED_BIT   = 12;
    localparam int RX_SHOOT_BIT = 11;
    localparam int RX_RSVD_W    = 11;
    localparam int RX_RSVD_LSB  = 0;

    typedef struct packed {
        logic [TX_MX_W-1:0]  mx;
        logic [TX_MY_W-1:0]  my;
        logic [TX_ETC_W-1:0] etc;
    } tx_frame_t;

    typedef struct packed {
        logic [RX_EX_W-1:0]   ex;
        logic [RX_EY_W-1:0]   ey;
        logic                 red;
        logic                 shoot;
        logic [RX_RSVD_W-1:0] rsvd;
    } rx_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

    function automatic logic [FRAME_BITS-1:0] pack_tx(input tx_frame_t f);
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[TX_MX_LSB  +: TX_MX_W]  = f.mx;
        w[TX_MY_LSB  +: TX_MY_W]  = f.my;
        w[TX_ETC_LSB +: TX_ETC_W] = f.etc;
        return w;
    endfunction

    function automatic rx_frame_t unpack_rx(input logic [FRAME_BITS-1:0] w);
        rx_frame_t f;
        f.ex    = w[RX_EX_LSB +: RX_EX_W];
        f.ey    = w[RX_EY_LSB +: RX_EY_W];
        f.red   = w[RX_RED_BIT];
        f.shoot = w[RX_SHOOT_BIT];
        f.rsvd  = w[RX_RSVD_LSB +: RX_RSVD_W];
        return f;
    endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK half-period divider: flags the last cycle of each low and high half while enabled.
module spi_edge_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             high_phase;
    logic             half_end;

    assign half_end  = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = half_end && !high_phase;
    assign fall_tick = half_end && high_phase;

    // Count cycles within a half-period; restart from the low half whenever disabled
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt    <= '0;
            high_phase <= 1'b0;
        end else if (half_end) begin
            div_cnt    <= '0;
            high_phase <= ~high_phase;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_link.sv
// SPI mode-0 master for the tracking link: sends a motor-command frame, captures the target report.
module spi_master_link #(
    parameter int CLK_DIV      = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int GAP_CYC      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  motor_xdata,
    input  logic [6:0]  motor_ydata,
    input  logic [16:0] mosi_etc,
    output logic        busy,
    output logic        done,
    output logic [9:0]  enemy_xdata,
    output logic [8:0]  enemy_ydata,
    output logic        red_detect,
    output logic        shoot,
    output logic [10:0] miso_etc_rsvd,
    output logic [15:0] frame_cnt,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs
);

    import spi_link_pkg::*;

    localparam int PH_W = 16;

    state_t                state;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [5:0]            bit_cnt;
    logic [PH_W-1:0]       phase_cnt;
    logic                  miso_meta;
    logic                  miso_sync;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  xfer_en;
    logic                  accept;
    tx_frame_t             tx_fields;
    logic [FRAME_BITS-1:0] tx_bits;
    rx_frame_t             rx_fields;

    assign tx_fields = '{mx: motor_xdata, my: motor_ydata, etc: mosi_etc};
    assign tx_bits   = pack_tx(tx_fields);
    assign rx_fields = unpack_rx(rx_shift);
    assign xfer_en   = (state == ST_XFER);

    // A start in the final GAP cycle is taken directly so back-to-back frames keep a
    // GAP_CYC-wide CS-high gap; busy then stays high across the frame boundary.
    assign accept = start && ((state == ST_IDLE) ||
                              ((state == ST_GAP) && (phase_cnt == '0)));

    spi_edge_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_edge_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (xfer_en),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    // Two-flop synchronizer for the asynchronous MISO line
    always_ff @(posedge clk) begin
        if (reset) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    // Frame sequencer: CS framing, SCLK/MOSI shifting, MISO capture and result publication
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cs            <= 1'b1;
            sclk          <= 1'b0;
            mosi          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            phase_cnt     <= '0;
            enemy_xdata   <= '0;
            enemy_ydata   <= '0;
            red_detect    <= 1'b0;
            shoot         <= 1'b0;
            miso_etc_rsvd <= '0;
            frame_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= ST_SETUP;
                busy      <= 1'b1;
                cs        <= 1'b0;
                sclk      <= 1'b0;
                tx_shift  <= tx_bits;
                mosi      <= tx_bits[FRAME_BITS-1];
                bit_cnt   <= '0;
                phase_cnt <= PH_W'(CS_SETUP_CYC - 1);
            end else begin
                unique case (state)
                    ST_IDLE: begin
                    end
                    ST_SETUP: begin
                        if (phase_cnt == '0) begin
                            state <= ST_XFER;
                        end else begin
                            phase_cnt <= phase_cnt - PH_W'(1);
                        end
                    end
                    ST_XFER: begin
                        if (rise_tick) begin
                            sclk <= 1'b1;
                        end
                        if (fall_tick) begin
                            sclk     <= 1'b0;
                            rx_shift <= {rx_shift[FRAME_BITS-2:0], miso_sync};
                            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                            if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                                mosi      <= 1'b0;
                                state     <= ST_HOLD;
                                phase_cnt <= PH_W'(CS_HOLD_CYC - 1);
                            end else begin
                                mosi    <= tx_shift[FRAME_BITS-2];
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (phase_cnt == '0) begin
                            cs            <= 1'b1;
                            done          <= 1'b1;
                            enemy_xdata   <= rx_fields.ex;
                            enemy_ydata   <= rx_fields.ey;
                            red_detect    <= rx_fields.red;
                            shoot         <= rx_fields.shoot;
                            miso_etc_rsvd <= rx_fields.rsvd;
                            frame_cnt     <= frame_cnt + 16'd1;
                            state         <= ST_GAP;
                            phase_cnt     <= PH_W'(GAP_CYC - 1);
                        end else begin
                            phase_cnt <= phase_cnt - PH_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (phase_cnt == '0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            phase_cnt <= phase_cnt - PH_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
